sd_clk_gen: RTL and testbench

- Host-controller-side SD clock generator. Consumes the Clock Control register (02Ch) fields written by the clock supply sequencer: Internal Clock Enable, SDCLK Frequency Select and SD Clock Enable.
- Derives the SD clock from the 50 MHz base clock as a registered divided signal, and reports Internal Clock Stable back into register 02Ch bit 1.
- Emits single-cycle edge strobes so command and data logic can run on the base clock.

---
 rtl/sd_host_pkg.sv | 43 ++++
 rtl/sd_clk_half_cntr.sv | 35 +++
 rtl/sd_clk_gen.sv | 155 +++++++++++++++
 tb/tb_sd_clk_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_host_pkg.sv
// Shared SD host controller definitions: Clock Control register layout, SDCLK
// frequency-select codes and the clock generator state encoding.
package sd_host_pkg;

  localparam logic [11:0] ClkCtrlOffset        = 12'h02C;
  localparam int unsigned ClkCtrlIntClkEnbBit    = 0;
  localparam int unsigned ClkCtrlIntClkStableBit = 1;
  localparam int unsigned ClkCtrlSdClkEnbBit     = 2;

  localparam logic [7:0] FreqSel80 = 8'h80;
  localparam logic [7:0] FreqSel40 = 8'h40;
  localparam logic [7:0] FreqSel20 = 8'h20;
  localparam logic [7:0] FreqSel10 = 8'h10;
  localparam logic [7:0] FreqSel08 = 8'h08;
  localparam logic [7:0] FreqSel04 = 8'h04;
  localparam logic [7:0] FreqSel02 = 8'h02;
  localparam logic [7:0] FreqSel01 = 8'h01;
  localparam logic [7:0] FreqSel00 = 8'h00;

  localparam logic [7:0] DefaultFreqSel = FreqSel40;

  typedef enum logic [4:0] {
    StOff    = 5'b00001,
    StSettle = 5'b00010,
    StIdle   = 5'b00100,
    StRun    = 5'b01000,
    StStop   = 5'b10000
  } clk_state_e;

  // Half-period in base-clock cycles; base mode (00h) runs as divide-by-2 and
  // any non-one-hot code falls back to the 390 kHz initialisation rate.
  function automatic logic [7:0] half_period(input logic [7:0] sel);
    logic [7:0] h;
    case (sel)
      FreqSel80, FreqSel40, FreqSel20, FreqSel10,
      FreqSel08, FreqSel04, FreqSel02, FreqSel01: h = sel;
      FreqSel00: h = 8'd1;
      default:   h = 8'd64;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/sd_clk_half_cntr.sv
// Loadable up-counter that wraps at a programmable limit and flags the
// terminal count; used both for SD clock half-periods and the settle timer.
module sd_clk_half_cntr #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc = (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sd_clk_gen.sv
// SD clock generator: divides the base clock per SDCLK Frequency Select,
// reports Internal Clock Stable and emits single-cycle SD clock edge strobes.
module sd_clk_gen
  import sd_host_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_clk_enb,
  input  logic [7:0] sdclk_freq_sel,
  input  logic       sd_clk_enb,
  output logic       int_clk_stable,
  output logic       sd_clk,
  output logic       sd_clk_pos_strb,
  output logic       sd_clk_neg_strb,
  output logic       sd_clk_run
);

  localparam logic [CNT_W-1:0] SettleLimit = CNT_W'(STABLE_CNT - 1);

  clk_state_e state_q, state_d;
  logic [7:0] sel_q, sel_d;
  logic       sd_clk_q, sd_clk_d;
  logic       stable_q, stable_d;
  logic       pos_q, pos_d;
  logic       neg_q, neg_d;

  logic             settle_load, settle_tc;
  logic             half_load, half_tc;
  logic [CNT_W-1:0] half_limit;

  assign half_limit = CNT_W'(half_period(sel_q) - 8'd1);

  sd_clk_half_cntr #(
    .CNT_W (CNT_W)
  ) u_settle_cntr (
    .clk    (clk),
    .reset  (reset),
    .load   (settle_load),
    .enable (state_q == StSettle),
    .limit  (SettleLimit),
    .tc     (settle_tc)
  );

  sd_clk_half_cntr #(
    .CNT_W (CNT_W)
  ) u_half_cntr (
    .clk    (clk),
    .reset  (reset),
    .load   (half_load),
    .enable (sd_clk_run),
    .limit  (half_limit),
    .tc     (half_tc)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sd_clk_d    = sd_clk_q;
    stable_d    = stable_q;
    pos_d       = 1'b0;
    neg_d       = 1'b0;
    settle_load = 1'b0;
    half_load   = 1'b0;

    if (!int_clk_enb) begin
      state_d  = StOff;
      sd_clk_d = 1'b0;
      stable_d = 1'b0;
      neg_d    = sd_clk_q;
    end else if (state_q != StOff && sdclk_freq_sel != sel_q) begin
      // Reprogram: drop the clock low and resettle at the new rate.
      state_d     = StSettle;
      sel_d       = sdclk_freq_sel;
      settle_load = 1'b1;
      sd_clk_d    = 1'b0;
      stable_d    = 1'b0;
      neg_d       = sd_clk_q;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d     = StSettle;
          sel_d       = sdclk_freq_sel;
          settle_load = 1'b1;
        end
        StSettle: begin
          if (settle_tc) begin
            state_d  = StIdle;
            stable_d = 1'b1;
          end
        end
        StIdle: begin
          if (sd_clk_enb) begin
            state_d   = StRun;
            sd_clk_d  = 1'b1;
            pos_d     = 1'b1;
            half_load = 1'b1;
          end
        end
        StRun: begin
          if (!sd_clk_enb) begin
            if (!sd_clk_q) begin
              state_d = StIdle;
            end else if (half_tc) begin
              state_d  = StIdle;
              sd_clk_d = 1'b0;
              neg_d    = 1'b1;
            end else begin
              state_d = StStop;
            end
          end else if (half_tc) begin
            sd_clk_d = ~sd_clk_q;
            pos_d    = ~sd_clk_q;
            neg_d    = sd_clk_q;
          end
        end
        StStop: begin
          if (half_tc) begin
            state_d  = StIdle;
            sd_clk_d = 1'b0;
            neg_d    = 1'b1;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StOff;
      sel_q    <= DefaultFreqSel;
      sd_clk_q <= 1'b0;
      stable_q <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sd_clk_q <= sd_clk_d;
      stable_q <= stable_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
    end
  end

  assign int_clk_stable  = stable_q;
  assign sd_clk          = sd_clk_q;
  assign sd_clk_pos_strb = pos_q;
  assign sd_clk_neg_strb = neg_q;
  assign sd_clk_run      = (state_q == StRun) || (state_q == StStop);

endmodule

// File: tb/tb_sd_clk_gen.sv
// Self-checking bench for sd_clk_gen: directed clock-control scenarios followed
// by random register traffic, all compared against a countdown-based model.
module tb_sd_clk_gen;

  localparam int STABLE = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       int_clk_enb;
  logic [7:0] sdclk_freq_sel;
  logic       sd_clk_enb;
  logic       int_clk_stable;
  logic       sd_clk;
  logic       sd_clk_pos_strb;
  logic       sd_clk_neg_strb;
  logic       sd_clk_run;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_clk_gen #(
    .STABLE_CNT (STABLE),
    .CNT_W      (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .int_clk_enb     (int_clk_enb),
    .sdclk_freq_sel  (sdclk_freq_sel),
    .sd_clk_enb      (sd_clk_enb),
    .int_clk_stable  (int_clk_stable),
    .sd_clk          (sd_clk),
    .sd_clk_pos_strb (sd_clk_pos_strb),
    .sd_clk_neg_strb (sd_clk_neg_strb),
    .sd_clk_run      (sd_clk_run)
  );

  // Reference model: remaining-cycle countdowns instead of state encoding.
  bit         m_on, m_stable, m_run, m_stopping, m_sdclk, m_pos, m_neg;
  int         m_settle_left, m_left;
  logic [7:0] m_sel;

  function automatic int half_of(input logic [7:0] s);
    if (s == 8'h00) return 1;
    if ($countones(s) == 1) return int'(s);
    return 64;
  endfunction

  task automatic model_edge();
    bit prev;
    prev  = m_sdclk;
    m_pos = 1'b0;
    m_neg = 1'b0;
    if (reset) begin
      m_on = 0; m_stable = 0; m_run = 0; m_stopping = 0; m_sdclk = 0;
      m_settle_left = 0; m_left = 0; m_sel = 8'h40;
    end else if (!int_clk_enb) begin
      m_on = 0; m_stable = 0; m_run = 0; m_stopping = 0; m_sdclk = 0;
      m_neg = prev;
    end else if (m_on && sdclk_freq_sel != m_sel) begin
      m_sel = sdclk_freq_sel; m_settle_left = STABLE;
      m_stable = 0; m_run = 0; m_stopping = 0; m_sdclk = 0;
      m_neg = prev;
    end else if (!m_on) begin
      m_on = 1; m_sel = sdclk_freq_sel; m_settle_left = STABLE;
    end else if (!m_stable) begin
      m_settle_left--;
      if (m_settle_left == 0) m_stable = 1;
    end else if (!m_run) begin
      if (sd_clk_enb) begin
        m_run = 1; m_stopping = 0; m_sdclk = 1; m_pos = 1;
        m_left = half_of(m_sel);
      end
    end else if (!m_stopping && !sd_clk_enb && !m_sdclk) begin
      m_run = 0;
    end else begin
      m_left--;
      if (m_stopping || !sd_clk_enb) begin
        if (m_left == 0) begin
          m_sdclk = 0; m_neg = 1; m_run = 0; m_stopping = 0;
        end else begin
          m_stopping = 1;
        end
      end else if (m_left == 0) begin
        m_sdclk = ~m_sdclk;
        m_pos   = m_sdclk;
        m_neg   = ~m_sdclk;
        m_left  = half_of(m_sel);
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("model_stable", int_clk_stable, m_stable);
    check("model_sd_clk", sd_clk, m_sdclk);
    check("model_pos", sd_clk_pos_strb, m_pos);
    check("model_neg", sd_clk_neg_strb, m_neg);
    check("model_run", sd_clk_run, m_run);
    check("strb_overlap", sd_clk_pos_strb & sd_clk_neg_strb, 1'b0);
  endtask

  // Steps until the chosen output is 1; n = steps taken, -1 on timeout.
  task automatic measure(input int which, input int limit, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      case (which)
        0:       hit = sd_clk_pos_strb;
        1:       hit = sd_clk_neg_strb;
        default: hit = int_clk_stable;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_sel(input logic [7:0] s, input int h);
    int n;
    sdclk_freq_sel = s;
    step();
    check("reprog_stable_low", int_clk_stable, 1'b0);
    check("reprog_sd_clk_low", sd_clk, 1'b0);
    measure(2, 40, n);
    check_int("resettle_cycles", n, STABLE);
    measure(0, 4, n);
    check_int("restart_latency", n, 1);
    measure(1, 300, n);
    check_int("high_phase", n, h);
    measure(0, 300, n);
    check_int("low_phase", n, h);
  endtask

  logic [7:0] codes [0:10];

  initial begin
    int n;
    int r;
    codes = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h03, 8'h41};

    reset = 1'b1; int_clk_enb = 1'b0; sd_clk_enb = 1'b0; sdclk_freq_sel = 8'h40;
    step();
    step();
    check("rst_stable", int_clk_stable, 1'b0);
    check("rst_sd_clk", sd_clk, 1'b0);
    check("rst_run", sd_clk_run, 1'b0);

    // Power-up at 40h
    reset = 1'b0; int_clk_enb = 1'b1;
    step();
    check("settle_start_stable", int_clk_stable, 1'b0);
    measure(2, 40, n);
    check_int("settle_cycles", n, STABLE);
    check("idle_sd_clk", sd_clk, 1'b0);
    sd_clk_enb = 1'b1;
    measure(0, 4, n);
    check_int("first_pos_latency", n, 1);
    measure(1, 300, n);
    check_int("high_40h", n, 64);
    measure(0, 300, n);
    check_int("low_40h", n, 64);

    run_sel(8'h01, 1);
    run_sel(8'h00, 1);
    run_sel(8'h80, 128);
    run_sel(8'h03, 64);
    run_sel(8'h40, 64);

    // Drop sd_clk_enb 10 cycles into the high phase
    repeat (9) step();
    sd_clk_enb = 1'b0;
    measure(1, 300, n);
    check_int("stop_tail", n, 64 - 9);
    check("stop_stable_kept", int_clk_stable, 1'b1);
    check("stop_run_low", sd_clk_run, 1'b0);
    repeat (5) step();
    check("stopped_low", sd_clk, 1'b0);

    // Reprogram 40h -> 10h while running
    sd_clk_enb = 1'b1;
    measure(0, 4, n);
    check_int("rerun_latency", n, 1);
    repeat (3) step();
    sdclk_freq_sel = 8'h10;
    step();
    check("chg_sd_clk", sd_clk, 1'b0);
    check("chg_stable", int_clk_stable, 1'b0);
    check("chg_neg", sd_clk_neg_strb, 1'b1);
    measure(2, 40, n);
    check_int("chg_settle", n, STABLE);
    measure(0, 4, n);
    check_int("chg_restart", n, 1);
    measure(1, 300, n);
    check_int("high_10h", n, 16);
    measure(0, 300, n);
    check_int("low_10h", n, 16);

    // Internal clock disable while high
    step();
    int_clk_enb = 1'b0;
    step();
    check("dis_sd_clk", sd_clk, 1'b0);
    check("dis_neg", sd_clk_neg_strb, 1'b1);
    check("dis_stable", int_clk_stable, 1'b0);
    int_clk_enb = 1'b1;
    measure(2, 40, n);
    check_int("reen_settle", n, STABLE + 1);
    measure(0, 300, n);

    // Reset in the middle of a high phase
    repeat (5) step();
    reset = 1'b1;
    step();
    check("mid_rst_sd_clk", sd_clk, 1'b0);
    check("mid_rst_stable", int_clk_stable, 1'b0);
    check("mid_rst_pos", sd_clk_pos_strb, 1'b0);
    check("mid_rst_neg", sd_clk_neg_strb, 1'b0);
    check("mid_rst_run", sd_clk_run, 1'b0);
    reset = 1'b0;
    step();
    check("post_rst_stable", int_clk_stable, 1'b0);
    measure(2, 40, n);
    check_int("post_rst_settle", n, STABLE);

    // Random register traffic
    for (int c = 0; c < 5000; c++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) int_clk_enb = ~int_clk_enb;
      else if (r < 30) sd_clk_enb = ~sd_clk_enb;
      else if (r < 38) begin
        r = int'($urandom_range(0, 11));
        sdclk_freq_sel = (r == 11) ? 8'($urandom_range(0, 255)) : codes[r];
      end else if (r < 40) reset = 1'b1;
      step();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
